regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the MIPS core; the next-generation replacement for the single-write/dual-read register file.
- Configurable register count, data width and number of read ports.
- Two write ports: port A for ALU writeback, port B for load return.
- Per-register pending-load scoreboard driving load-use stall detection.
- Register 0 hardwired to zero; optional write-to-read bypass.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of 2, >=2)
ADDR_W, $clog2(NUM_REGS), register address width (derived; do not override)
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  port i's register has a load outstanding
wa_en  in  1  ALU write enable
wa_addr  in  ADDR_W  ALU write register
wa_data  in  DATA_W  ALU write data
wb_en  in  1  load-return write enable
wb_addr  in  ADDR_W  load-return register
wb_data  in  DATA_W  load-return data
ld_issue  in  1  load issued this cycle, marks ld_addr pending
ld_addr  in  ADDR_W  destination of issued load
stall  out  1  OR of rd_busy over all ports

Behaviour:
- Reset (rst_n low, asynchronous): all registers cleared to 0 and all busy bits cleared.
  - rd_data then reads 0; rd_busy and stall read 0.
  - Reset mid-operation discards any outstanding load.
- Reads are combinational, zero latency:
  - rd_data[i] = 0 if rd_addr[i] == 0, else the stored register value.
- Writes commit on the rising clk edge; new data is visible on reads the cycle after.
- Writes to address 0 are ignored on both ports; ld_issue to address 0 sets no busy bit.
- Both write ports targeting the same nonzero register in one cycle: port B (load) wins, port A is dropped.
- Different addresses on the two ports: both commit in the same cycle.
- Scoreboard: one busy bit per register, updated on the rising edge.
  - Set when ld_issue=1, on ld_addr.
  - Cleared when wb_en=1, on wb_addr.
  - Set and clear on the same register in one cycle: set wins (a new load is issued over the returning one).
  - wa_en does not alter busy bits.
- rd_busy[i] = busy[rd_addr[i]], combinational; always 0 for address 0. stall = |rd_busy.
- No overflow or underflow conditions:
  - A redundant set is idempotent.
  - A clear of a non-busy register is a no-op.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - rd_data[i] forwards same-cycle write data when rd_addr[i] != 0 matches an enabled write address; port B data takes priority over port A.
  - rd_busy[i] is suppressed (0) when wb_en=1 and wb_addr == rd_addr[i], so the load result is consumed with no stall that cycle.
- Undefined: reads return only committed state; a read of a register being written returns the old value; busy clears one cycle after the load return.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W_DEF=32, NUM_REGS_DEF=32
  - typedef reg_addr_t (5-bit)
  - constant REG_ZERO=0
- One sub-module: regfile_scoreboard, holding the busy-bit vector with set/clear/priority logic and the per-port busy lookup.
- Storage and read muxing stay in regfile_mp.

Test Plan:
- Reset, then read all 32 addresses on both ports -> rd_data=0 throughout, stall=0.
- wa_en, addr 5, data 0xDEADBEEF; next cycle read port 0 addr 5 -> 0xDEADBEEF. Write 0x1234 to addr 0, read addr 0 -> 0.
- Same cycle wa(addr 7, 0x11) and wb(addr 7, 0x22) -> addr 7 reads 0x22. Different addresses (3 and 4) -> both commit.
- ld_issue addr 9, read port 1 addr 9 -> rd_busy[1]=1, stall=1 until the wb_en addr 9 edge, then 0. ld_issue and wb_en both on addr 9 in one cycle -> busy stays 1.
- REGFILE_BYPASS_EN: wb_en addr 9 data 0xCAFE with read addr 9 same cycle -> rd_data=0xCAFE, rd_busy=0. Without the macro -> old value and rd_busy=1 that cycle.
- Assert rst_n low with addr 9 busy and registers written -> immediately stall=0 and all reads 0, without waiting for a clk edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core constants and types.
// Used by regfile_mp and regfile_scoreboard (optional REGFILE_BYPASS_EN forwarding).
package mips_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned NUM_REGS_DEF = 32;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one busy bit per register plus per-port busy lookup.
// With REGFILE_BYPASS_EN defined, a same-cycle load return hides the busy bit.
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic                     ld_issue,
    input  logic [ADDR_W-1:0]        ld_addr
);

    localparam logic [ADDR_W-1:0] AddrZero = ADDR_W'(REG_ZERO);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_d;
    logic [ADDR_W-1:0]   w_rd_addr [NUM_RD];

    // Clear first so a load issued over a returning one keeps the bit set.
    always_comb begin
        w_busy_d = r_busy;
        if (wb_en) begin
            w_busy_d[wb_addr] = 1'b0;
        end
        if (ld_issue) begin
            w_busy_d[ld_addr] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd_addr[i] = rd_addr[i*ADDR_W +: ADDR_W];
            if (w_rd_addr[i] != AddrZero) begin
                rd_busy[i] = r_busy[w_rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
                if (wb_en && (wb_addr == w_rd_addr[i])) begin
                    rd_busy[i] = 1'b0;
                end
`endif
            end
        end
    end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (ALU, load return), NUM_RD read ports, r0 = 0.
// Optional feature macro: REGFILE_BYPASS_EN forwards same-cycle write data to the reads.
module regfile_mp
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     ld_issue,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     stall
);

    localparam logic [ADDR_W-1:0] AddrZero = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [ADDR_W-1:0] w_rd_addr [NUM_RD];
    logic [DATA_W-1:0] w_rd_val [NUM_RD];
    logic              w_wa_ok;
    logic              w_wb_ok;

    assign w_wa_ok = wa_en && (wa_addr != AddrZero);
    assign w_wb_ok = wb_en && (wb_addr != AddrZero);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_wb_ok && (wb_addr == ADDR_W'(r))) begin
                    r_regs[r] <= wb_data;
                end else if (w_wa_ok && (wa_addr == ADDR_W'(r))) begin
                    r_regs[r] <= wa_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd_addr[i] = rd_addr[i*ADDR_W +: ADDR_W];
            w_rd_val[i]  = '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_rd_addr[i] == ADDR_W'(r)) begin
                    w_rd_val[i] = r_regs[r];
                end
            end
`ifdef REGFILE_BYPASS_EN
            if (w_wb_ok && (wb_addr == w_rd_addr[i])) begin
                w_rd_val[i] = wb_data;
            end else if (w_wa_ok && (wa_addr == w_rd_addr[i])) begin
                w_rd_val[i] = wa_data;
            end
`endif
            rd_data[i*DATA_W +: DATA_W] = w_rd_val[i];
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .ld_issue (ld_issue),
        .ld_addr  (ld_addr)
    );

    assign stall = |rd_busy;

endmodule : regfile_mp
